uart_rx_fifo: RTL and testbench

- Serial receive front end feeding the memory-mapped peripheral's UART receive data and status registers.
- Samples the asynchronous PC_Uart_rxd line with 16x oversampling and decodes 8N1 frames.
- Buffers received bytes in a small first-word-fall-through FIFO so the CPU can poll without losing back-to-back characters.
- Reports framing and overrun errors as sticky flags.

---
 rtl/uart_rx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling feeding a small
// first-word-fall-through FIFO, plus sticky framing/overrun error flags.
//
// Ports
//   sysclk       system clock, rising edge
//   reset        asynchronous active-low reset
//   PC_Uart_rxd  asynchronous serial input, idles high
//   rd_en        pop request for the FIFO head (ignored while empty)
//   err_clr      clears frame_err and overrun (a same-cycle set wins)
//   rx_data      FIFO head byte, valid while rx_valid is 1
//   rx_valid     FIFO not empty
//   rx_count     number of occupied FIFO entries (0..DEPTH)
//   frame_err    sticky: stop bit sampled low
//   overrun      sticky: a byte completed while the FIFO was full
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 4,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          PC_Uart_rxd,
  input  logic          rd_en,
  input  logic          err_clr,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic [AW:0]   rx_count,
  output logic          frame_err,
  output logic          overrun
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DW  = $clog2(DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic [1:0]    sync;
  logic          rxd_s;
  logic [DW-1:0] div_cnt;
  logic          tick;

  state_t        state, state_nx;
  logic [3:0]    tick_cnt, tick_cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shift_q, shift_nx;
  logic          push, set_frame;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    rx_hold;
  logic          pop, full, do_push, ovf;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) sync <= '1;
    else        sync <= {sync[0], PC_Uart_rxd};
  end
  assign rxd_s = sync[1];

  // Free-running 16x oversampling tick.
  assign tick = (div_cnt == DW'(DIV - 1));
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_cnt_nx;
      bit_idx  <= bit_idx_nx;
      shift_q  <= shift_nx;
    end
  end

  // Start is confirmed at mid-bit (tick_cnt 7); every later sample is taken
  // 16 ticks on, i.e. where tick_cnt wraps 15->0.
  always_comb begin
    state_nx    = state;
    tick_cnt_nx = tick_cnt;
    bit_idx_nx  = bit_idx;
    shift_nx    = shift_q;
    push        = 1'b0;
    set_frame   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxd_s) begin
          tick_cnt_nx = '0;
          state_nx    = START;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == 4'd7) begin
            if (!rxd_s) begin
              tick_cnt_nx = '0;
              bit_idx_nx  = '0;
              state_nx    = DATA;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            tick_cnt_nx = tick_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_cnt_nx = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shift_nx   = {rxd_s, shift_q[7:1]};
            bit_idx_nx = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tick_cnt_nx = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            if (rxd_s) begin
              push     = 1'b1;
              state_nx = IDLE;
            end else begin
              set_frame = 1'b1;
              state_nx  = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FIFO: a pop on a full FIFO frees the slot for a same-cycle push.
  assign rx_valid = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop      = rd_en && rx_valid;
  assign do_push  = push && (!full || pop);
  assign ovf      = push && full && !pop;

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rx_hold <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rx_hold <= mem[rd_ptr];
      end
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Once drained, the output keeps the last byte popped rather than
  // exposing whatever stale entry the read pointer now addresses.
  assign rx_data  = rx_valid ? mem[rd_ptr] : rx_hold;
  assign rx_count = count;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (set_frame)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovf)          overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BIT   = 64;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       rxd    = 1'b1;
  logic       rd_en  = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD(25000), .DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .reset(reset), .PC_Uart_rxd(rxd), .rd_en(rd_en),
    .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_count(rx_count), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 sysclk = ~sysclk;

  int unsigned cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: queue of bytes held plus the two sticky flags.
  logic [7:0] q[$];
  logic       m_frame = 1'b0;
  logic       m_over  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(rx_count), q.size());
    check({tag, "_valid"}, 32'(rx_valid), 32'(q.size() != 0));
    if (q.size() != 0) check({tag, "_data"}, 32'(rx_data), 32'(q[0]));
    check({tag, "_ferr"}, 32'(frame_err), 32'(m_frame));
    check({tag, "_ovr"}, 32'(overrun), 32'(m_over));
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge sysclk);
  endtask

  // Frame arrival per the model: a good frame adds a byte unless the FIFO
  // is full (then overrun), unless the caller popped in the push cycle.
  task automatic model_rx(input logic [7:0] b, input bit stop_ok, input bit popped);
    if (!stop_ok) m_frame = 1'b1;
    else begin
      if (popped && q.size() != 0) void'(q.pop_front());
      if (q.size() < DEPTH) q.push_back(b);
      else m_over = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int unsigned stop_len);
    rxd = 1'b0;
    wait_cyc(BIT);
    for (int unsigned i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(BIT);
    end
    rxd = stop;
    wait_cyc(stop_len);
    rxd = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge sysclk);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge sysclk);
    err_clr = 1'b0;
    m_frame = 1'b0;
    m_over  = 1'b0;
  endtask

  task automatic align4();
    while (cyc % 4 != 0) @(negedge sysclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned s, v, lat;
    logic [7:0] b;

    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(5);
    check_state("reset");
    check("reset_data", 32'(rx_data), 32'h0);

    pop_one();
    check_state("empty_pop");

    // Single byte; also captures start-to-push latency for later alignment.
    align4();
    s = cyc;
    v = s;
    fork
      send_frame(8'hA5, 1'b1, BIT);
      begin
        while (!rx_valid && (cyc - s) < 800) @(negedge sysclk);
        v = cyc;
      end
    join
    lat = v - s;
    check("latency_window", 32'((lat >= 606) && (lat <= 613)), 32'd1);
    model_rx(8'hA5, 1'b1, 1'b0);
    check_state("single");
    pop_one();
    check_state("single_pop");

    // Fill and overrun.
    for (int unsigned i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, BIT);
      model_rx(8'(i), 1'b1, 1'b0);
    end
    check_state("fill");
    for (int unsigned i = 0; i < 4; i++) begin
      check_state("drain");
      pop_one();
    end
    check_state("drained");
    clear_err();
    check_state("ovr_clr");

    // Glitch rejection.
    rxd = 1'b0;
    wait_cyc(20);
    rxd = 1'b1;
    wait_cyc(100);
    check_state("glitch");
    send_frame(8'h3C, 1'b1, BIT);
    model_rx(8'h3C, 1'b1, 1'b0);
    check_state("after_glitch");
    pop_one();

    // Framing error with an extended low stop period.
    send_frame(8'h7E, 1'b0, 200);
    model_rx(8'h7E, 1'b0, 1'b0);
    wait_cyc(BIT);
    check_state("frame_err");
    send_frame(8'h81, 1'b1, BIT);
    model_rx(8'h81, 1'b1, 1'b0);
    check_state("after_frame");
    pop_one();
    clear_err();
    check_state("ferr_clr");

    // Full-FIFO boundary: pop lands exactly on the push edge of byte 5.
    for (int unsigned i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, BIT);
      model_rx(b, 1'b1, 1'b0);
    end
    check_state("full4");
    b = 8'($urandom_range(0, 255));
    align4();
    s = cyc;
    fork
      send_frame(b, 1'b1, BIT);
      begin
        while (cyc != s + lat - 1 && cyc < s + 900) @(negedge sysclk);
        rd_en = 1'b1;
        @(negedge sysclk);
        rd_en = 1'b0;
      end
    join
    model_rx(b, 1'b1, 1'b1);
    check_state("boundary");
    for (int unsigned i = 0; i < 4; i++) begin
      check_state("bnd_drain");
      pop_one();
    end
    check_state("bnd_empty");

    // Randomized traffic with random gaps and pops.
    for (int unsigned i = 0; i < 10; i++) begin
      wait_cyc($urandom_range(0, 40));
      b = 8'($urandom);
      send_frame(b, 1'b1, BIT);
      model_rx(b, 1'b1, 1'b0);
      check_state("rand");
      if ($urandom_range(0, 1) == 1) pop_one();
    end
    while (q.size() != 0) begin
      check_state("rand_drain");
      pop_one();
    end
    clear_err();
    check_state("rand_end");

    // Reset during bit 3 of 0x55 with two bytes queued.
    for (int unsigned i = 0; i < 2; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, BIT);
      model_rx(b, 1'b1, 1'b0);
    end
    check_state("pre_reset");
    b = 8'h55;
    rxd = 1'b0;
    wait_cyc(BIT);
    for (int unsigned i = 0; i < 3; i++) begin
      rxd = b[i];
      wait_cyc(BIT);
    end
    rxd = b[3];
    wait_cyc(BIT / 2);
    reset = 1'b0;
    #1;
    q.delete();
    m_frame = 1'b0;
    m_over  = 1'b0;
    check_state("reset_mid");
    check("reset_mid_data", 32'(rx_data), 32'h0);
    rxd = 1'b1;
    wait_cyc(10);
    reset = 1'b1;
    wait_cyc(200);
    check_state("post_reset");
    send_frame(8'hC3, 1'b1, BIT);
    model_rx(8'hC3, 1'b1, 1'b0);
    check_state("after_reset");
    pop_one();
    check_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
